hpp_gen_sequencer: RTL and testbench

HPP_GEN_SEQUENCER -- requirements
Module: hpp_gen_sequencer

---
 rtl/hpp_gen_sequencer.sv | 129 ++++++++++++
 tb/tb_hpp_gen_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hpp_gen_sequencer.sv
// hpp_gen_sequencer: walks the HPP lattice grid once per generation.
// Each cell is read, passed combinationally through the external collision
// PE, and written back one cycle later at the same address. Generations start
// on a step pulse or on a frame sync while run is held, and are never queued.
module hpp_gen_sequencer #(
    parameter int COLS   = 320,
    parameter int ROWS   = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic              frame_sync,
    input  logic              artist_mode_in,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [4:0]        mem_rd_data,
    output logic [4:0]        pe_state,
    output logic              pe_artist,
    input  logic [4:0]        pe_state_next,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [4:0]        mem_wr_data,
    output logic              busy,
    output logic              gen_done,
    output logic [15:0]       gen_count
);

    localparam int                CELLS = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(CELLS - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              artist_q, artist_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [15:0]       gen_count_q, gen_count_d;
    logic              start;

    assign start = step | (run & frame_sync);

    // Next-state and next-output computation; all outputs are registered.
    always_comb begin
        state_d     = state_q;
        rd_en_d     = rd_en_q;
        rd_addr_d   = rd_addr_q;
        artist_d    = artist_q;
        done_d      = 1'b0;
        gen_count_d = gen_count_q;
        // The write pipeline simply trails the read by one cycle, so the
        // write address is always one behind the read address.
        wr_en_d     = rd_en_q;
        wr_addr_d   = rd_addr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SWEEP;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    artist_d  = artist_mode_in;
                end
            end
            SWEEP: begin
                if (rd_addr_q == LAST) begin
                    state_d   = DRAIN;
                    rd_en_d   = 1'b0;
                    rd_addr_d = '0;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // Last write is on the bus this cycle; announce completion next.
                state_d     = DONE;
                done_d      = 1'b1;
                gen_count_d = gen_count_q + 16'd1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            artist_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            gen_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            artist_q    <= artist_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            gen_count_q <= gen_count_d;
        end
    end

    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_addr_q;
    assign pe_state    = mem_rd_data;
    assign pe_artist   = artist_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = wr_addr_q;
    // PE result is only meaningful while a write is in flight; hold 0 otherwise.
    assign mem_wr_data = wr_en_q ? pe_state_next : 5'd0;
    assign busy        = busy_q;
    assign gen_done    = done_q;
    assign gen_count   = gen_count_q;

endmodule

// File: tb/tb_hpp_gen_sequencer.sv
// Directed bench for hpp_gen_sequencer on a 4x2 grid with a memory model
// and a small HPP collision PE model.
module tb_hpp_gen_sequencer;

    localparam int COLS  = 4;
    localparam int ROWS  = 2;
    localparam int AW    = 3;
    localparam int CELLS = COLS * ROWS;

    logic          clk = 1'b0;
    logic          reset, run, step, frame_sync, artist_mode_in;
    logic          mem_rd_en, mem_wr_en, pe_artist, busy, gen_done;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic [4:0]    mem_rd_data, pe_state, pe_state_next, mem_wr_data;
    logic [15:0]   gen_count;

    logic [4:0]    mem      [CELLS];
    logic [4:0]    init_mem [CELLS];
    logic          ld;

    int            n_chk = 0;
    int            n_bad = 0;
    logic [15:0]   exp_cnt;

    always #5 clk = ~clk;

    hpp_gen_sequencer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .frame_sync(frame_sync),
        .artist_mode_in(artist_mode_in), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .pe_state(pe_state), .pe_artist(pe_artist),
        .pe_state_next(pe_state_next), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .busy(busy), .gen_done(gen_done), .gen_count(gen_count)
    );

    // HPP collision: {obstacle,a,b,c,d}; a/c and b/d are opposite directions.
    function automatic logic [4:0] pe_fn(input logic [4:0] s);
        if (s[4])                 return {1'b1, s[1], s[0], s[3], s[2]};
        else if (s[3:0] == 4'b1010) return 5'b00101;
        else if (s[3:0] == 4'b0101) return 5'b01010;
        else                      return s;
    endfunction

    assign pe_state_next = pe_fn(pe_state);

    // Grid memory: 1-cycle registered read, write on strobe, bulk preload.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
        if (ld) begin
            for (int k = 0; k < CELLS; k++) mem[k] <= init_mem[k];
        end else if (mem_wr_en) begin
            mem[mem_wr_addr] <= mem_wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic load_mem();
        @(negedge clk); ld = 1'b1;
        @(negedge clk); ld = 1'b0;
    endtask

    // One step-started generation with a full cycle-by-cycle timeline check.
    task automatic do_gen(input logic art_exp, input logic tog, input logic [15:0] cnt_exp);
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            chk("rd_en", mem_rd_en, 1);
            chk("rd_addr", mem_rd_addr, i);
            chk("busy", busy, 1);
            chk("pe_artist", pe_artist, art_exp);
            chk("wr_en", mem_wr_en, i != 0);
            chk("done_low", gen_done, 0);
            if (i != 0) begin
                chk("wr_addr", mem_wr_addr, i - 1);
                chk("wr_data", mem_wr_data, pe_fn(init_mem[i-1]));
                chk("pe_state", pe_state, init_mem[i-1]);
            end
            if (tog && i == 3) artist_mode_in = ~artist_mode_in;
            @(negedge clk);
        end
        // DRAIN
        chk("drain_rd_en", mem_rd_en, 0);
        chk("drain_wr_en", mem_wr_en, 1);
        chk("drain_wr_addr", mem_wr_addr, CELLS - 1);
        chk("drain_wr_data", mem_wr_data, pe_fn(init_mem[CELLS-1]));
        chk("drain_busy", busy, 1);
        chk("drain_done", gen_done, 0);
        chk("drain_artist", pe_artist, art_exp);
        @(negedge clk);
        // DONE
        chk("done_pulse", gen_done, 1);
        chk("done_wr_en", mem_wr_en, 0);
        chk("done_rd_en", mem_rd_en, 0);
        chk("done_busy", busy, 1);
        chk("done_count", gen_count, cnt_exp);
        @(negedge clk);
        // IDLE
        chk("idle_busy", busy, 0);
        chk("idle_done", gen_done, 0);
        chk("idle_count", gen_count, cnt_exp);
    endtask

    initial begin
        logic [4:0] exp37 [CELLS];
        logic       found;
        reset = 1'b1; run = 1'b0; step = 1'b0; frame_sync = 1'b0;
        artist_mode_in = 1'b0; ld = 1'b0;
        for (int k = 0; k < CELLS; k++) init_mem[k] = 5'd0;

        // Reset state
        @(negedge clk);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_rd_addr", mem_rd_addr, 0);
        chk("rst_wr_addr", mem_wr_addr, 0);
        chk("rst_wr_data", mem_wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", gen_done, 0);
        chk("rst_count", gen_count, 0);
        chk("rst_artist", pe_artist, 0);
        reset = 1'b0;

        // Basic step-started generation
        load_mem();
        do_gen(1'b0, 1'b0, 16'd1);

        // Collision pattern with obstacle
        init_mem = '{5'b00001, 5'b00011, 5'b00000, 5'b01010,
                     5'b00000, 5'b10100, 5'b00000, 5'b00000};
        exp37    = '{5'b00001, 5'b00011, 5'b00000, 5'b00101,
                     5'b00000, 5'b10001, 5'b00000, 5'b00000};
        load_mem();
        do_gen(1'b0, 1'b0, 16'd2);
        for (int k = 0; k < CELLS; k++) chk("mem_after_pe", mem[k], exp37[k]);

        // Artist mode latched per generation
        for (int k = 0; k < CELLS; k++) init_mem[k] = 5'd0;
        load_mem();
        artist_mode_in = 1'b1;
        do_gen(1'b1, 1'b1, 16'd3);
        do_gen(1'b0, 1'b0, 16'd4);

        // Free-running on frame_sync; extra starts while busy are dropped
        exp_cnt = 16'd4;
        run = 1'b1;
        for (int f = 0; f < 3; f++) begin
            @(negedge clk); frame_sync = 1'b1; step = (f == 0);
            @(negedge clk); frame_sync = 1'b0; step = 1'b0;
            chk("run_busy", busy, 1);
            repeat (3) @(negedge clk);
            frame_sync = 1'b1; step = 1'b1;
            if (f == 1) run = 1'b0;
            @(negedge clk); frame_sync = 1'b0; step = 1'b0;
            repeat (14) @(negedge clk);
            exp_cnt = exp_cnt + 16'd1;
            chk("run_idle", busy, 0);
            chk("run_count", gen_count, exp_cnt);
            run = 1'b1;
        end
        run = 1'b0;
        @(negedge clk); frame_sync = 1'b1;
        @(negedge clk); frame_sync = 1'b0;
        chk("norun_busy", busy, 0);
        chk("norun_count", gen_count, exp_cnt);

        // Reset while address 4 is being written
        for (int k = 0; k < CELLS; k++) init_mem[k] = 5'b01010;
        load_mem();
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (mem_wr_en && mem_wr_addr == 3'd4) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("wr4_seen", found, 1);
        reset = 1'b1;
        #1;
        chk("abort_wr_en", mem_wr_en, 0);
        chk("abort_rd_en", mem_rd_en, 0);
        chk("abort_count", gen_count, 0);
        chk("abort_busy", busy, 0);
        chk("abort_wr_data", mem_wr_data, 0);
        chk("abort_rd_addr", mem_rd_addr, 0);
        repeat (2) @(negedge clk);
        chk("abort_mem3", mem[3], 5'b00101);
        chk("abort_mem4", mem[4], 5'b01010);
        reset = 1'b0;
        load_mem();
        do_gen(1'b0, 1'b0, 16'd1);
        for (int k = 0; k < CELLS; k++) chk("rewrite_mem", mem[k], 5'b00101);

        // gen_count wrap from 0xFFFF
        @(negedge clk); force dut.gen_count_q = 16'hFFFF;
        @(negedge clk); release dut.gen_count_q;
        @(negedge clk);
        chk("preset_count", gen_count, 16'hFFFF);
        for (int k = 0; k < CELLS; k++) init_mem[k] = 5'd0;
        load_mem();
        do_gen(1'b0, 1'b0, 16'h0000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
